// File: rtl/nios_pio_pkg.sv
// Shared definitions for the button PIO initiator: FSM encoding and slave register map.
package nios_pio_pkg;

   typedef enum logic [3:0] {
      ST_INIT,
      ST_IDLE,
      ST_MASK,
      ST_E_ADR,
      ST_E_DAT,
      ST_E_CLR,
      ST_L_ADR,
      ST_L_DAT,
      ST_EMIT
   } state_e;

   localparam logic [1:0] PIO_ADDR_DATA = 2'd0;
   localparam logic [1:0] PIO_ADDR_MASK = 2'd2;
   localparam logic [1:0] PIO_ADDR_EDGE = 2'd3;

endpackage

// File: rtl/nios_system_4a_button_irq_servicer.sv
// Hardware replacement for the button ISR: programs irq_mask, services irq by reading and clearing
// edge_capture plus the live level, and hands each event downstream over valid/ready.
module nios_system_4a_button_irq_servicer
   import nios_pio_pkg::*;
#(
   parameter int                W             = 3,
   parameter logic [W-1:0]      IRQ_MASK_INIT = 3'b111,
   parameter int                CNT_W         = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             irq,
   input  logic [31:0]      readdata,
   output logic [1:0]       address,
   output logic             chipselect,
   output logic             write_n,
   output logic [31:0]      writedata,
   input  logic             cfg_mask_wr,
   input  logic [W-1:0]     cfg_mask,
   output logic             evt_valid,
   input  logic             evt_ready,
   output logic [W-1:0]     evt_edges,
   output logic [W-1:0]     evt_level,
   output logic [CNT_W-1:0] evt_count,
   output logic             init_done
);

   state_e             state_q, state_d;
   logic               mask_pend_q, mask_pend_d;
   logic [W-1:0]       mask_reg_q, mask_reg_d;
   logic [W-1:0]       edges_q, edges_d;
   logic [W-1:0]       level_q, level_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               init_done_q, init_done_d;
   logic [W-1:0]       wdat;
   logic               unused_readdata;

   assign unused_readdata = ^readdata[31:W];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_INIT;
         mask_pend_q <= 1'b0;
         mask_reg_q  <= IRQ_MASK_INIT;
         edges_q     <= '0;
         level_q     <= '0;
         count_q     <= '0;
         init_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         mask_pend_q <= mask_pend_d;
         mask_reg_q  <= mask_reg_d;
         edges_q     <= edges_d;
         level_q     <= level_d;
         count_q     <= count_d;
         init_done_q <= init_done_d;
      end
   end

   // A request arriving in IDLE is taken straight away so it beats an irq seen in the same cycle.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_INIT:  state_d = ST_IDLE;
         ST_IDLE: begin
            if (mask_pend_q || cfg_mask_wr) state_d = ST_MASK;
            else if (irq)                   state_d = ST_E_ADR;
         end
         ST_MASK:  state_d = ST_IDLE;
         ST_E_ADR: state_d = ST_E_DAT;
         ST_E_DAT: state_d = (readdata[W-1:0] == '0) ? ST_IDLE : ST_E_CLR;
         ST_E_CLR: state_d = ST_L_ADR;
         ST_L_ADR: state_d = ST_L_DAT;
         ST_L_DAT: state_d = ST_EMIT;
         ST_EMIT:  if (evt_ready) state_d = ST_IDLE;
         default:  state_d = ST_INIT;
      endcase
   end

   always_comb begin
      mask_pend_d = mask_pend_q;
      mask_reg_d  = mask_reg_q;
      edges_d     = edges_q;
      level_d     = level_q;
      count_d     = count_q;
      init_done_d = init_done_q;
      if (cfg_mask_wr) begin
         mask_pend_d = 1'b1;
         mask_reg_d  = cfg_mask;
      end else if (state_q == ST_MASK) begin
         mask_pend_d = 1'b0;
      end
      if (state_q == ST_INIT)                 init_done_d = 1'b1;
      if (state_q == ST_E_DAT)                edges_d     = readdata[W-1:0];
      if (state_q == ST_L_DAT)                level_d     = readdata[W-1:0];
      if (state_q == ST_EMIT && evt_ready)    count_d     = count_q + 1'b1;
   end

   // Reset gating keeps the bus idle while reset is held even though the state already reads INIT.
   always_comb begin
      chipselect = 1'b0;
      write_n    = 1'b1;
      address    = PIO_ADDR_DATA;
      wdat       = '0;
      evt_valid  = 1'b0;
      if (reset_n) begin
         unique case (state_q)
            ST_INIT: begin
               chipselect = 1'b1;
               write_n    = 1'b0;
               address    = PIO_ADDR_MASK;
               wdat       = IRQ_MASK_INIT;
            end
            ST_MASK: begin
               chipselect = 1'b1;
               write_n    = 1'b0;
               address    = PIO_ADDR_MASK;
               wdat       = mask_reg_q;
            end
            ST_E_ADR: begin
               chipselect = 1'b1;
               address    = PIO_ADDR_EDGE;
            end
            ST_E_CLR: begin
               chipselect = 1'b1;
               write_n    = 1'b0;
               address    = PIO_ADDR_EDGE;
            end
            ST_L_ADR: begin
               chipselect = 1'b1;
               address    = PIO_ADDR_DATA;
            end
            ST_EMIT:  evt_valid = 1'b1;
            default: ;
         endcase
      end
   end

   assign writedata = {{(32-W){1'b0}}, wdat};
   assign evt_edges = edges_q;
   assign evt_level = level_q;
   assign evt_count = count_q;
   assign init_done = init_done_q;

endmodule
